// File: rtl/fb_pkg.sv
// Shared constants, grant kind and address helper for the character frame buffer.
package fb_pkg;

   localparam int unsigned COLS   = 40;
   localparam int unsigned ROWS   = 15;
   localparam int unsigned ADDR_W = 10;
   localparam int unsigned COL_W  = 6;
   localparam int unsigned ROW_W  = 4;
   localparam int unsigned DATA_W = 8;

   localparam logic [DATA_W-1:0] SPACE_CHAR = 8'h20;

   typedef enum logic [1:0] {
      GNT_IDLE  = 2'd0,
      GNT_READ  = 2'd1,
      GNT_WRITE = 2'd2
   } grant_e;

   // Linear RAM address of a character cell.
   function automatic logic [ADDR_W-1:0] fb_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
      return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
   endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous write FIFO; flush keeps only a same-cycle push.
module fb_wr_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [IDX_W-1:0] wr_idx;
   logic [WIDTH-1:0] mem_q [DEPTH];

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                    (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
   assign rdata_o = mem_q[rd_ptr_q[IDX_W-1:0]];

   // Pointer next-state; a flush restarts both pointers at slot 0.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      wr_idx   = wr_ptr_q[IDX_W-1:0];
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = push_i ? PTR_W'(1) : '0;
         wr_idx   = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_idx] <= wdata_i;
   end

endmodule

// File: rtl/char_fb_ctrl.sv
// Character frame-buffer RAM arbiter: scan-out reads vs. queued SPI writes.
module char_fb_ctrl
   import fb_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   input  logic              frame_sync,
   input  logic              rd_req,
   input  logic [5:0]        rd_col,
   input  logic [3:0]        rd_row,
   output logic              rd_ack,
   output logic              rd_valid,
   output logic [7:0]        rd_data,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              wr_overflow,
   input  logic              clear_ovf,
   output logic              frame_done,
   output logic [5:0]        cur_col,
   output logic [3:0]        cur_row
);

   localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

   grant_e              grant;
   logic                fifo_full, fifo_empty;
   logic [DATA_W-1:0]   fifo_head;
   logic                push, pop, rd_oor, forced;

   logic [COL_W-1:0]    cur_col_q, cur_col_d;
   logic [ROW_W-1:0]    cur_row_q, cur_row_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                rd_valid_q, rd_oor_q;
   logic                ovf_q, ovf_d;
   logic                frame_done_q, frame_done_d;
   logic                cur_last;

   assign rd_oor   = (rd_col >= COL_W'(COLS)) || (rd_row >= ROW_W'(ROWS));
   assign forced   = (starve_q == STARVE_W'(STARVE_MAX)) && !fifo_empty;
   assign cur_last = (cur_col_q == COL_W'(COLS - 1)) && (cur_row_q == ROW_W'(ROWS - 1));

   // Arbitration and RAM port drive; out-of-range reads leave the port to a write.
   always_comb begin
      grant     = GNT_IDLE;
      rd_ack    = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (rst_n) begin
         if (rd_req && !forced) begin
            rd_ack = 1'b1;
            if (!rd_oor)          grant = GNT_READ;
            else if (!fifo_empty) grant = GNT_WRITE;
         end else if (!fifo_empty) begin
            grant = GNT_WRITE;
         end
      end
      case (grant)
         GNT_READ: begin
            mem_en   = 1'b1;
            mem_addr = fb_addr(rd_row, rd_col);
         end
         GNT_WRITE: begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = fb_addr(cur_row_q, cur_col_q);
            mem_wdata = fifo_head;
         end
         default: ;
      endcase
   end

   assign pop  = (grant == GNT_WRITE);
   assign push = byte_valid && (!fifo_full || pop || frame_sync);

   // Cursor, starvation counter, overflow flag and frame-done next state.
   always_comb begin
      cur_col_d    = cur_col_q;
      cur_row_d    = cur_row_q;
      starve_d     = starve_q;
      ovf_d        = ovf_q;
      frame_done_d = pop && cur_last;

      if (frame_sync) begin
         cur_col_d = '0;
         cur_row_d = '0;
      end else if (pop) begin
         if (cur_col_q == COL_W'(COLS - 1)) begin
            cur_col_d = '0;
            cur_row_d = (cur_row_q == ROW_W'(ROWS - 1)) ? '0 : cur_row_q + ROW_W'(1);
         end else begin
            cur_col_d = cur_col_q + COL_W'(1);
         end
      end

      if (frame_sync || fifo_empty || pop) starve_d = '0;
      else if (rd_ack)                     starve_d = starve_q + STARVE_W'(1);

      if (byte_valid && !push) ovf_d = 1'b1;
      else if (clear_ovf)      ovf_d = 1'b0;
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_col_q    <= '0;
         cur_row_q    <= '0;
         starve_q     <= '0;
         ovf_q        <= 1'b0;
         frame_done_q <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_oor_q     <= 1'b0;
      end else begin
         cur_col_q    <= cur_col_d;
         cur_row_q    <= cur_row_d;
         starve_q     <= starve_d;
         ovf_q        <= ovf_d;
         frame_done_q <= frame_done_d;
         rd_valid_q   <= rd_ack;
         rd_oor_q     <= rd_ack && rd_oor;
      end
   end

   // Read return: RAM data arrives the cycle after the grant; out-of-range reads return a space.
   always_comb begin
      rd_data = '0;
      if (rd_valid_q) rd_data = rd_oor_q ? SPACE_CHAR : mem_rdata;
   end

   assign rd_valid    = rd_valid_q;
   assign wr_overflow = ovf_q;
   assign frame_done  = frame_done_q;
   assign cur_col     = cur_col_q;
   assign cur_row     = cur_row_q;

   fb_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_wr_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (frame_sync),
      .wdata_i (byte_data),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_char_fb_ctrl.sv
// Directed bench for char_fb_ctrl with a behavioural RAM model.
module tb_char_fb_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       frame_sync;
   logic       rd_req;
   logic [5:0] rd_col;
   logic [3:0] rd_row;
   logic       rd_ack, rd_valid;
   logic [7:0] rd_data;
   logic       mem_en, mem_we;
   logic [9:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       wr_overflow;
   logic       clear_ovf;
   logic       frame_done;
   logic [5:0] cur_col;
   logic [3:0] cur_row;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] ram [1024];

   char_fb_ctrl dut (
      .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
      .frame_sync(frame_sync), .rd_req(rd_req), .rd_col(rd_col), .rd_row(rd_row),
      .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .wr_overflow(wr_overflow), .clear_ovf(clear_ovf),
      .frame_done(frame_done), .cur_col(cur_col), .cur_row(cur_row)
   );

   always #5 clk = ~clk;

   // Single-port RAM model with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   typedef struct {
      logic [5:0] col;
      logic [3:0] row;
      logic       exp_en;
      logic [9:0] exp_addr;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive_idle();
      byte_valid = 1'b0; byte_data = 8'h00; frame_sync = 1'b0;
      rd_req = 1'b0; rd_col = '0; rd_row = '0; clear_ovf = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive_idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [7:0] pat(input int k);
      return 8'((k * 7 + 3) & 255);
   endfunction

   int fd_count, fd_cycle;
   logic prev_ack, wr;

   initial begin
      drive_idle();
      rst_n = 1'b0;

      // Test 1: reset state, then three back-to-back bytes.
      do_reset();
      #1;
      check("reset_rd_valid", rd_valid, 0);
      check("reset_rd_data", rd_data, 0);
      check("reset_ovf", wr_overflow, 0);
      check("reset_frame_done", frame_done, 0);
      check("reset_cur_col", cur_col, 0);
      check("reset_cur_row", cur_row, 0);
      check("reset_mem_en", mem_en, 0);
      for (int i = 0; i < 4; i++) begin
         byte_valid = (i < 3);
         byte_data  = 8'h61 + 8'(i);
         #1;
         if (i >= 1) begin
            check("t1_we", mem_we, 1);
            check("t1_addr", mem_addr, i - 1);
            check("t1_wdata", mem_wdata, 8'h61 + 8'(i - 1));
         end
         tick();
      end
      byte_valid = 1'b0;
      #1;
      check("t1_cur_col", cur_col, 3);
      check("t1_cur_row", cur_row, 0);

      // Test 2: full frame of writes, frame_done once after addr 599.
      do_reset();
      fd_count = 0; fd_cycle = -1;
      for (int k = 0; k <= 602; k++) begin
         byte_valid = (k < 600);
         byte_data  = pat(k);
         #1;
         if (k >= 1 && k <= 600) begin
            check("t2_we", mem_we, 1);
            check("t2_addr", mem_addr, k - 1);
            check("t2_wdata", mem_wdata, pat(k - 1));
         end
         if (frame_done) begin fd_count++; fd_cycle = k; end
         tick();
      end
      byte_valid = 1'b0;
      #1;
      check("t2_fd_count", fd_count, 1);
      check("t2_fd_cycle", fd_cycle, 601);
      check("t2_cur_col", cur_col, 0);
      check("t2_cur_row", cur_row, 0);

      // Table: in-range and out-of-range reads against the frame just written.
      vecs[0] = '{col: 6'd5,  row: 4'd2,  exp_en: 1'b1, exp_addr: 10'd85,  exp_data: pat(85)};
      vecs[1] = '{col: 6'd39, row: 4'd14, exp_en: 1'b1, exp_addr: 10'd599, exp_data: pat(599)};
      vecs[2] = '{col: 6'd0,  row: 4'd0,  exp_en: 1'b1, exp_addr: 10'd0,   exp_data: pat(0)};
      vecs[3] = '{col: 6'd40, row: 4'd0,  exp_en: 1'b0, exp_addr: 10'd0,   exp_data: 8'h20};
      vecs[4] = '{col: 6'd0,  row: 4'd15, exp_en: 1'b0, exp_addr: 10'd0,   exp_data: 8'h20};
      vecs[5] = '{col: 6'd63, row: 4'd15, exp_en: 1'b0, exp_addr: 10'd0,   exp_data: 8'h20};
      do_reset();
      for (int v = 0; v < 6; v++) begin
         rd_req = 1'b1; rd_col = vecs[v].col; rd_row = vecs[v].row;
         #1;
         check("tab_ack", rd_ack, 1);
         check("tab_en", mem_en, vecs[v].exp_en);
         if (vecs[v].exp_en) begin
            check("tab_we", mem_we, 0);
            check("tab_addr", mem_addr, vecs[v].exp_addr);
         end
         tick();
         rd_req = 1'b0;
         #1;
         check("tab_valid", rd_valid, 1);
         check("tab_data", rd_data, vecs[v].exp_data);
         tick();
      end

      // Test 3: held read with two queued bytes; starvation forces writes.
      do_reset();
      rd_req = 1'b1; rd_col = 6'd5; rd_row = 4'd2;
      byte_valid = 1'b1; byte_data = 8'h70;
      #1;
      check("t3_first_ack", rd_ack, 1);
      check("t3_first_addr", mem_addr, 85);
      tick();
      byte_data = 8'h71;
      prev_ack = 1'b1;
      for (int i = 0; i < 20; i++) begin
         byte_valid = (i == 0);
         #1;
         wr = (i == 8) || (i == 17);
         check("t3_ack", rd_ack, !wr);
         check("t3_we", mem_we, wr);
         check("t3_en", mem_en, 1);
         if (wr) begin
            check("t3_waddr", mem_addr, (i == 8) ? 0 : 1);
            check("t3_wdata", mem_wdata, (i == 8) ? 8'h70 : 8'h71);
         end else begin
            check("t3_raddr", mem_addr, 85);
         end
         check("t3_rd_valid", rd_valid, prev_ack);
         prev_ack = !wr;
         tick();
      end

      // Test 4: overflow while reads hold the port, clear, then push into a popping full FIFO.
      do_reset();
      rd_req = 1'b1; rd_col = 6'd5; rd_row = 4'd2;
      for (int i = 0; i < 6; i++) begin
         byte_valid = 1'b1; byte_data = 8'(i + 1);
         #1;
         check("t4_ack", rd_ack, 1);
         tick();
      end
      byte_valid = 1'b0;
      #1;
      check("t4_ovf_set", wr_overflow, 1);
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      #1;
      check("t4_ovf_clr", wr_overflow, 0);
      rd_req = 1'b0; byte_valid = 1'b1; byte_data = 8'h07;
      #1;
      check("t4_full_we", mem_we, 1);
      check("t4_full_addr", mem_addr, 0);
      check("t4_full_wdata", mem_wdata, 8'h01);
      tick();
      byte_valid = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         #1;
         check("t4_we", mem_we, 1);
         check("t4_addr", mem_addr, j);
         check("t4_wdata", mem_wdata, (j < 4) ? 8'(j + 1) : 8'h07);
         tick();
      end
      #1;
      check("t4_drained", mem_en, 0);
      check("t4_no_ovf", wr_overflow, 0);

      // Test 6: frame_sync with queued bytes, then reset mid-stream.
      do_reset();
      for (int k = 0; k <= 130; k++) begin
         byte_valid = (k < 130); byte_data = 8'(k);
         tick();
      end
      byte_valid = 1'b0;
      #1;
      check("t6_cur_col", cur_col, 10);
      check("t6_cur_row", cur_row, 3);
      rd_req = 1'b1; rd_col = 6'd0; rd_row = 4'd0;
      byte_valid = 1'b1; byte_data = 8'h78;
      tick();
      byte_data = 8'h79;
      tick();
      rd_req = 1'b0; frame_sync = 1'b1; byte_data = 8'h7a;
      #1;
      check("t6_sync_we", mem_we, 1);
      check("t6_sync_addr", mem_addr, 130);
      check("t6_sync_wdata", mem_wdata, 8'h78);
      tick();
      frame_sync = 1'b0; byte_valid = 1'b0;
      #1;
      check("t6_post_col", cur_col, 0);
      check("t6_post_row", cur_row, 0);
      check("t6_z_we", mem_we, 1);
      check("t6_z_addr", mem_addr, 0);
      check("t6_z_wdata", mem_wdata, 8'h7a);
      check("t6_no_fd", frame_done, 0);
      tick();
      #1;
      check("t6_flushed", mem_en, 0);
      check("t6_col_after_z", cur_col, 1);
      rd_req = 1'b1; byte_valid = 1'b1; byte_data = 8'h55;
      tick();
      byte_data = 8'h56;
      tick();
      byte_valid = 1'b0; rst_n = 1'b0;
      tick();
      rst_n = 1'b1; rd_req = 1'b0;
      #1;
      check("t6_rst_valid", rd_valid, 0);
      check("t6_rst_col", cur_col, 0);
      check("t6_rst_row", cur_row, 0);
      check("t6_rst_empty", mem_en, 0);
      tick();
      #1;
      check("t6_rst_valid2", rd_valid, 0);
      check("t6_rst_empty2", mem_en, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
